vlc_bit_packer: RTL and testbench

Bitstream packer directly downstream of the DC/AC entropy encoders. Accepts one variable-length codeword per cycle as a right-aligned value plus a bit length. Concatenates the codewords MSB-first into 32-bit output words and buffers them in a small FIFO for the slice writer. A flush request pads the final partial word with zeros and marks it as last.

---
 rtl/vlc_bit_packer.sv | 150 +++++++++++++++
 tb/tb_vlc_bit_packer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vlc_bit_packer.sv
// vlc_bit_packer: concatenates right-aligned variable-length codewords MSB-first
// into 32-bit words, queued in a small output FIFO. A flush pads the final
// partial word with zeros and tags it as last.
// Optional build macro: VLC_PACKER_BYTE_SWAP_EN -- byte-reverses out_data at the
// FIFO output so the first stream byte lands on bits 7:0.
module vlc_bit_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_code,
  input  logic [5:0]  in_len,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        flush_done,
  output logic [31:0] bit_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  // acc is left-aligned: acc[63] is the oldest pending bit; bits below fill are
  // always zero, which makes the flush zero-padding free.
  logic [63:0] acc, acc_n;
  logic [5:0]  fill, fill_n;
  logic [0:0]  state, state_n;
  logic        rst_done;
  logic        done_n;

  word_t       mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic        push, pop;
  word_t       push_w;
  word_t       head;

  logic        accept, take_flush;
  logic [5:0]  len_c;
  logic [31:0] code_m;
  logic [63:0] code_al, acc_app;
  logic [6:0]  fill_sum;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_ready && !empty;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready   = rst_done && (state == S_IDLE) && !full;
  assign accept     = in_valid && in_ready;
  assign take_flush = flush && in_ready;

  // Clamp length, mask stale upper bits, then left-align below current fill.
  always_comb begin
    len_c    = (in_len > 6'd32) ? 6'd32 : in_len;
    code_m   = (len_c == 6'd32) ? in_code : (in_code & ((32'd1 << len_c) - 32'd1));
    code_al  = {code_m, 32'b0} << (6'd32 - len_c);
    acc_app  = acc | (code_al >> fill);
    fill_sum = {1'b0, fill} + {1'b0, len_c};
  end

  // Packing / flush next-state logic; at most one FIFO push per cycle.
  always_comb begin
    acc_n   = acc;
    fill_n  = fill;
    state_n = state;
    push    = 1'b0;
    push_w  = '0;
    done_n  = 1'b0;
    if (state == S_IDLE) begin
      if (accept) begin
        acc_n  = acc_app;
        fill_n = fill_sum[5:0];
        if (fill_sum >= 7'd32) begin
          push        = 1'b1;
          push_w.data = acc_app[63:32];
          acc_n       = acc_app << 32;
          fill_n      = 6'(fill_sum - 7'd32);
        end
      end
      if (take_flush) state_n = S_FLUSH;
    end else if (!full) begin
      if (fill > 6'd32) begin
        push        = 1'b1;
        push_w.data = acc[63:32];
        acc_n       = acc << 32;
        fill_n      = fill - 6'd32;
      end else begin
        if (fill != 6'd0) begin
          push        = 1'b1;
          push_w.last = 1'b1;
          push_w.data = acc[63:32];
        end
        acc_n   = '0;
        fill_n  = '0;
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end
  end

  // Packer state, counters and FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      fill       <= '0;
      state      <= S_IDLE;
      rst_done   <= 1'b0;
      flush_done <= 1'b0;
      bit_count  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      acc        <= acc_n;
      fill       <= fill_n;
      state      <= state_n;
      rst_done   <= 1'b1;
      flush_done <= done_n;
      if (accept) bit_count <= bit_count + {26'b0, len_c};
      if (push)   wr_ptr    <= wr_ptr + 1'b1;
      if (pop)    rd_ptr    <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_w;
  end

  assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_last  = head.last;
`ifdef VLC_PACKER_BYTE_SWAP_EN
  assign out_data  = {head.data[7:0], head.data[15:8], head.data[23:16], head.data[31:24]};
`else
  assign out_data  = head.data;
`endif

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Scoreboard bench for vlc_bit_packer: expected words are queued at stimulus
// time and popped by an independent output monitor.
module tb_vlc_bit_packer;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_code = 0;
  logic [5:0]  in_len = 0;
  logic        flush = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_data;
  logic        out_last;
  logic        flush_done;
  logic [31:0] bit_count;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];
  logic [31:0] w [6];

  vlc_bit_packer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_len(in_len), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .flush_done(flush_done), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef VLC_PACKER_BYTE_SWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_word(input logic last, input logic [31:0] d);
    exp_q.push_back({last, sw(d)});
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [31:0] c, input logic [5:0] l, input logic f);
    int n;
    n = 0;
    in_valid = 1; in_code = c; in_len = l; flush = f;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: every word the consumer takes is checked in order.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", {out_last, out_data}, 0);
      else chk("out_word", {out_last, out_data}, exp_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) w[i] = 32'h1111_1111 * (i + 1);

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bit_count", bit_count, 0);
    @(negedge clk); reset_n = 1;
    repeat (2) @(posedge clk); #1;

    // 1: 3 + 29 bits form exactly one word
    expect_word(0, 32'hBFFF_FFFF);
    send(32'h5, 6'd3, 0);
    send(32'h1FFF_FFFF, 6'd29, 0);
    chk("s1_bit_count", bit_count, 32);
    drain();

    // 2: code with simultaneous flush; exact flush timing
    expect_word(1, 32'hA000_0000);
    chk("s2_ready_pre", in_ready, 1);
    in_valid = 1; in_code = 32'h5; in_len = 6'd3; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("s2_ready_flush", in_ready, 0);
    chk("s2_done_early", flush_done, 0);
    @(posedge clk); #1;
    chk("s2_done_pulse", flush_done, 1);
    chk("s2_ready_back", in_ready, 1);
    @(posedge clk); #1;
    chk("s2_done_clear", flush_done, 0);
    chk("s2_bit_count", bit_count, 35);
    drain();

    // 3: backpressure fills FIFO, then drains in order
    for (int i = 0; i < 6; i++) expect_word(0, w[i]);
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(w[i], 6'd32, 0);
    in_valid = 1; in_code = w[4]; in_len = 6'd32;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s3_full_stall", in_ready, 0);
    end
    chk("s3_head_valid", out_valid, 1);
    chk("s3_head_data", out_data, sw(w[0]));
    @(posedge clk); #1;
    out_ready = 1;
    send(w[4], 6'd32, 0);
    send(w[5], 6'd32, 0);
    drain();
    chk("s3_bit_count", bit_count, 227);

    // 4: masking, zero length, length clamp
    expect_word(0, 32'hF000_0000);
    send(32'hFFFF_FFFF, 6'd4, 0);
    send(32'hFFFF_FFFF, 6'd0, 0);
    send(32'h0, 6'd40, 0);
    chk("s4_bit_count", bit_count, 263);
    drain();
    expect_word(1, 32'h0);   // the 4 pending zero bits, padded
    send(32'h0, 6'd0, 1);
    drain();
    chk("s4_bit_count_after", bit_count, 263);

    // 5: async reset mid-flush with words queued
    out_ready = 0;
    send(32'hFFFF_FFFF, 6'd32, 0);
    send(32'hFFFF_FFFF, 6'd32, 0);
    in_valid = 1; in_code = 32'h1; in_len = 6'd3; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("s5_in_flush", in_ready, 0);
    reset_n = 0;
    #1;
    chk("s5_rst_out_valid", out_valid, 0);
    chk("s5_rst_out_data", out_data, 0);
    chk("s5_rst_out_last", out_last, 0);
    chk("s5_rst_flush_done", flush_done, 0);
    chk("s5_rst_bit_count", bit_count, 0);
    chk("s5_rst_in_ready", in_ready, 0);
    exp_q.delete();
    @(negedge clk); reset_n = 1; out_ready = 1;
    repeat (2) @(posedge clk); #1;
    expect_word(1, 32'h8000_0000);
    send(32'h1, 6'd1, 1);
    drain();
    chk("s5_bit_count", bit_count, 1);
    repeat (5) @(posedge clk); #1;
    chk("final_q_empty", exp_q.size(), 0);
    chk("final_no_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
